// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the datapath bus driveout logic.
// Holds the bus-source code width, the driveout vector width, the
// "no source" code, the default number of legal sources and the
// sequencer FSM state encoding.
package cpu_bus_pkg;

    localparam int SRC_W            = 5;
    localparam int DRV_W            = 32;
    localparam int NUM_SOURCES_DFLT = 24;
    localparam int CNT_W            = $clog2(16);

    // Code 31 means "nobody drives the bus".
    localparam logic [SRC_W-1:0] SRC_NONE = 5'd31;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GAP   = 2'd1,
        ST_DRIVE = 2'd2
    } seq_state_e;

endpackage

// File: rtl/bus_drive_sequencer_if.sv
// Request/driveout bundle between the control unit and the sequencer.
//   req_valid/req_code : control unit asks for a bus source (31 = release)
//   req_ready          : sequencer can take a request this cycle
//   drive_en/drive_code: one-hot driveout lines and the code being driven
//   busy/done/err      : progress and status pulses back to the control unit
// master = control unit side, slave = sequencer side.
interface bus_drive_sequencer_if;
    import cpu_bus_pkg::*;

    logic             req_valid;
    logic [SRC_W-1:0] req_code;
    logic             req_ready;
    logic [DRV_W-1:0] drive_en;
    logic [SRC_W-1:0] drive_code;
    logic             busy;
    logic             done;
    logic             err;

    modport master (
        output req_valid, req_code,
        input  req_ready, drive_en, drive_code, busy, done, err
    );

    modport slave (
        input  req_valid, req_code,
        output req_ready, drive_en, drive_code, busy, done, err
    );

endinterface

// File: rtl/decoder_5_32.sv
// Purely combinational 5-to-32 one-hot decoder.
//   code_i   : source code; 31 decodes to all-zero (no source)
//   onehot_o : one-hot driveout, bit n set for code n
module decoder_5_32
    import cpu_bus_pkg::*;
(
    input  logic [SRC_W-1:0] code_i,
    output logic [DRV_W-1:0] onehot_o
);

    // One-hot decode with the release code mapped to no driveout
    always_comb begin
        onehot_o = {DRV_W{1'b0}};
        if (code_i != SRC_NONE) begin
            onehot_o[code_i] = 1'b1;
        end else begin
            onehot_o = {DRV_W{1'b0}};
        end
    end

endmodule

// File: rtl/bus_drive_sequencer.sv
// Turns a bus-source code into a one-hot driveout with a guaranteed
// all-off gap before each grant and a fixed grant length.
//   clk : rising-edge clock
//   clr : synchronous active-high reset
//   bus : slave side of the request/driveout bundle
// Every output is a flop. drive_en is derived from the current state, so
// the visible grant trails the DRIVE state by one cycle; that extra cycle
// is what provides the all-off cycle right after each accept.
module bus_drive_sequencer
    import cpu_bus_pkg::*;
#(
    parameter int NUM_SOURCES  = NUM_SOURCES_DFLT,
    parameter int GAP_CYCLES   = 1,
    parameter int DRIVE_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  clr,
    bus_drive_sequencer_if.slave  bus
);

    localparam logic [SRC_W-1:0] LAST_LEGAL_EXCL = SRC_W'(NUM_SOURCES);
    localparam logic [CNT_W-1:0] GAP_LOAD =
        (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] DRV_LOAD = CNT_W'(DRIVE_CYCLES - 1);

    seq_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SRC_W-1:0] code_q, code_d;
    logic [DRV_W-1:0] drive_en_q, drive_en_d;
    logic [SRC_W-1:0] drive_code_q, drive_code_d;
    logic             req_ready_q, req_ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic             accept_s;
    logic             legal_s;
    logic             release_s;
    logic             in_drive_s;
    logic [DRV_W-1:0] dec_s;

    decoder_5_32 u_dec (
        .code_i   (code_q),
        .onehot_o (dec_s)
    );

    // Request classification and FSM next state / counter reload
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        code_d    = code_q;
        accept_s  = bus.req_valid && req_ready_q;
        legal_s   = (bus.req_code < LAST_LEGAL_EXCL);
        release_s = (bus.req_code == SRC_NONE);
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    code_d = bus.req_code;
                    if (legal_s) begin
                        if (GAP_CYCLES == 0) begin
                            state_d = ST_DRIVE;
                            cnt_d   = DRV_LOAD;
                        end else begin
                            state_d = ST_GAP;
                            cnt_d   = GAP_LOAD;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GAP: begin
                if (cnt_q == {CNT_W{1'b0}}) begin
                    state_d = ST_DRIVE;
                    cnt_d   = DRV_LOAD;
                end else begin
                    cnt_d = cnt_q - 4'(1);
                end
            end
            ST_DRIVE: begin
                if (cnt_q == {CNT_W{1'b0}}) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Registered output values derived from the current state
    always_comb begin
        in_drive_s   = (state_q == ST_DRIVE);
        drive_en_d   = in_drive_s ? dec_s  : {DRV_W{1'b0}};
        drive_code_d = in_drive_s ? code_q : SRC_NONE;
        busy_d       = (state_q != ST_IDLE);
        // Illegal and release codes finish immediately, without GAP/DRIVE.
        done_d       = (in_drive_s && (cnt_q == {CNT_W{1'b0}})) ||
                       (accept_s && !legal_s);
        err_d        = accept_s && !legal_s && !release_s;
        // Ready drops for the accept cycle and stays low until the FSM
        // is seen back in IDLE, which lines up with the grant release.
        req_ready_d  = (state_q == ST_IDLE) && !accept_s;
    end

    // State, counter, latched code and output registers
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q      <= ST_IDLE;
            cnt_q        <= {CNT_W{1'b0}};
            code_q       <= SRC_NONE;
            drive_en_q   <= {DRV_W{1'b0}};
            drive_code_q <= SRC_NONE;
            req_ready_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            code_q       <= code_d;
            drive_en_q   <= drive_en_d;
            drive_code_q <= drive_code_d;
            req_ready_q  <= req_ready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign bus.drive_en   = drive_en_q;
    assign bus.drive_code = drive_code_q;
    assign bus.req_ready  = req_ready_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;

endmodule

// File: tb/tb_bus_drive_sequencer.sv
// Bench for bus_drive_sequencer: a per-cycle vector table on a default
// instance, hand sequences on a GAP=2/DRIVE=3 instance, and a per-cycle
// monitor relating drive_en to drive_code on both instances.
module tb_bus_drive_sequencer;

    localparam int GB = 2;
    localparam int DB = 3;

    logic clk = 1'b0;
    logic clr = 1'b1;
    always #5 clk = ~clk;

    bus_drive_sequencer_if bus_a ();
    bus_drive_sequencer_if bus_b ();

    bus_drive_sequencer #(.NUM_SOURCES(24), .GAP_CYCLES(1), .DRIVE_CYCLES(1)) dut_a (
        .clk (clk), .clr (clr), .bus (bus_a.slave)
    );
    bus_drive_sequencer #(.NUM_SOURCES(24), .GAP_CYCLES(GB), .DRIVE_CYCLES(DB)) dut_b (
        .clk (clk), .clr (clr), .bus (bus_b.slave)
    );

    typedef struct {
        logic        clr;
        logic        valid;
        logic [4:0]  code;
        logic [31:0] en;
        logic [4:0]  dcode;
        logic        rdy;
        logic        busy;
        logic        done;
        logic        err;
    } vec_t;

    vec_t vecs[$];
    int   n_vec  = 0;
    int   n_miss = 0;
    bit   chk_en = 1'b0;

    // Reference 32-to-5 bus-select encoder: 31 when nothing is driven
    function automatic logic [4:0] enc(input logic [31:0] v);
        logic [4:0] r;
        r = 5'd31;
        for (int i = 0; i < 32; i++) begin
            if (v[i]) r = 5'(i);
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic add(input logic c, input logic v, input logic [4:0] code,
                       input logic [31:0] en, input logic [4:0] dc,
                       input logic rdy, input logic busy, input logic done, input logic err);
        vec_t t;
        t.clr = c; t.valid = v; t.code = code; t.en = en; t.dcode = dc;
        t.rdy = rdy; t.busy = busy; t.done = done; t.err = err;
        vecs.push_back(t);
    endtask

    task automatic chk_b(input string nm, input logic [31:0] en, input logic [4:0] dc,
                         input logic rdy, input logic busy, input logic done);
        chk({nm, " en"},   bus_b.drive_en, en);
        chk({nm, " code"}, {27'd0, bus_b.drive_code}, {27'd0, dc});
        chk({nm, " rdy"},  {31'd0, bus_b.req_ready}, {31'd0, rdy});
        chk({nm, " busy"}, {31'd0, bus_b.busy}, {31'd0, busy});
        chk({nm, " done"}, {31'd0, bus_b.done}, {31'd0, done});
        chk({nm, " err"},  {31'd0, bus_b.err}, 32'd0);
    endtask

    // Every cycle: drive_en is at most one-hot and encodes to drive_code
    always @(negedge clk) begin
        if (chk_en) begin
            chk("enc_a", {27'd0, enc(bus_a.drive_en)}, {27'd0, bus_a.drive_code});
            chk("onehot_a", {31'd0, $onehot0(bus_a.drive_en)}, 32'd1);
            chk("enc_b", {27'd0, enc(bus_b.drive_en)}, {27'd0, bus_b.drive_code});
            chk("onehot_b", {31'd0, $onehot0(bus_b.drive_en)}, 32'd1);
        end
    end

    initial begin
        logic [31:0] e_en;
        logic [4:0]  e_dc;

        bus_a.req_valid = 1'b0; bus_a.req_code = 5'd0;
        bus_b.req_valid = 1'b0; bus_b.req_code = 5'd0;

        // clr, valid, code | drive_en, drive_code, ready, busy, done, err
        add(1'b1, 1'b0, 5'd0,  32'h0,  5'd31, 1'b0, 1'b0, 1'b0, 1'b0); // reset
        add(1'b1, 1'b0, 5'd0,  32'h0,  5'd31, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 5'd0,  32'h0,  5'd31, 1'b1, 1'b0, 1'b0, 1'b0); // ready after clr
        add(1'b0, 1'b1, 5'd5,  32'h0,  5'd31, 1'b0, 1'b0, 1'b0, 1'b0); // accept 5
        add(1'b0, 1'b0, 5'd0,  32'h0,  5'd31, 1'b0, 1'b1, 1'b0, 1'b0); // gap
        add(1'b0, 1'b0, 5'd0,  32'h20, 5'd5,  1'b0, 1'b1, 1'b1, 1'b0); // grant
        add(1'b0, 1'b0, 5'd0,  32'h0,  5'd31, 1'b1, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b1, 5'd24, 32'h0,  5'd31, 1'b0, 1'b0, 1'b1, 1'b1); // illegal
        add(1'b0, 1'b0, 5'd0,  32'h0,  5'd31, 1'b1, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b1, 5'd31, 32'h0,  5'd31, 1'b0, 1'b0, 1'b1, 1'b0); // release
        add(1'b0, 1'b0, 5'd0,  32'h0,  5'd31, 1'b1, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b1, 5'd30, 32'h0,  5'd31, 1'b0, 1'b0, 1'b1, 1'b1); // illegal top
        add(1'b0, 1'b0, 5'd0,  32'h0,  5'd31, 1'b1, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b1, 5'd0,  32'h0,  5'd31, 1'b0, 1'b0, 1'b0, 1'b0); // accept 0
        add(1'b0, 1'b1, 5'd1,  32'h0,  5'd31, 1'b0, 1'b1, 1'b0, 1'b0); // held, ignored
        add(1'b0, 1'b1, 5'd1,  32'h1,  5'd0,  1'b0, 1'b1, 1'b1, 1'b0);
        add(1'b0, 1'b1, 5'd1,  32'h0,  5'd31, 1'b1, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b1, 5'd1,  32'h0,  5'd31, 1'b0, 1'b0, 1'b0, 1'b0); // accept 1
        add(1'b0, 1'b1, 5'd1,  32'h0,  5'd31, 1'b0, 1'b1, 1'b0, 1'b0);
        add(1'b0, 1'b1, 5'd1,  32'h2,  5'd1,  1'b0, 1'b1, 1'b1, 1'b0);
        add(1'b0, 1'b0, 5'd0,  32'h0,  5'd31, 1'b1, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b1, 5'd3,  32'h0,  5'd31, 1'b0, 1'b0, 1'b0, 1'b0); // accept 3
        add(1'b0, 1'b1, 5'd9,  32'h0,  5'd31, 1'b0, 1'b1, 1'b0, 1'b0); // 9 while busy
        add(1'b0, 1'b1, 5'd9,  32'h8,  5'd3,  1'b0, 1'b1, 1'b1, 1'b0); // grant unchanged
        add(1'b0, 1'b0, 5'd0,  32'h0,  5'd31, 1'b1, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            clr             = vecs[i].clr;
            bus_a.req_valid = vecs[i].valid;
            bus_a.req_code  = vecs[i].code;
            @(posedge clk);
            #1;
            chk_en = 1'b1;
            chk($sformatf("v%0d en", i),   bus_a.drive_en, vecs[i].en);
            chk($sformatf("v%0d code", i), {27'd0, bus_a.drive_code}, {27'd0, vecs[i].dcode});
            chk($sformatf("v%0d rdy", i),  {31'd0, bus_a.req_ready}, {31'd0, vecs[i].rdy});
            chk($sformatf("v%0d busy", i), {31'd0, bus_a.busy}, {31'd0, vecs[i].busy});
            chk($sformatf("v%0d done", i), {31'd0, bus_a.done}, {31'd0, vecs[i].done});
            chk($sformatf("v%0d err", i),  {31'd0, bus_a.err}, {31'd0, vecs[i].err});
        end
        bus_a.req_valid = 1'b0;

        // GAP=2, DRIVE=3, code 23: grant visible from k+3 to k+5
        bus_b.req_valid = 1'b1;
        bus_b.req_code  = 5'd23;
        @(posedge clk);
        #1;
        bus_b.req_valid = 1'b0;
        for (int i = 0; i <= GB + DB + 1; i++) begin
            if (i > 0) begin
                @(posedge clk);
                #1;
            end
            e_en = ((i >= GB + 1) && (i <= GB + DB)) ? 32'h0080_0000 : 32'h0;
            e_dc = ((i >= GB + 1) && (i <= GB + DB)) ? 5'd23 : 5'd31;
            chk_b($sformatf("g23 k+%0d", i), e_en, e_dc, (i == GB + DB + 1),
                  ((i >= 1) && (i <= GB + DB)), (i == GB + DB));
        end

        // clr during the grant of code 9: dropped at the next edge, no done
        bus_b.req_valid = 1'b1;
        bus_b.req_code  = 5'd9;
        @(posedge clk);
        #1;
        bus_b.req_valid = 1'b0;
        repeat (GB + 1) begin
            @(posedge clk);
            #1;
        end
        chk_b("c9 grant", 32'h0000_0200, 5'd9, 1'b0, 1'b1, 1'b0);
        clr = 1'b1;
        @(posedge clk);
        #1;
        chk_b("c9 clr", 32'h0, 5'd31, 1'b0, 1'b0, 1'b0);
        clr = 1'b0;
        @(posedge clk);
        #1;
        chk_b("c9 after1", 32'h0, 5'd31, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk_b("c9 after2", 32'h0, 5'd31, 1'b1, 1'b0, 1'b0);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
